alu_exec: RTL and testbench

- Multi-cycle 8-bit execute stage directly downstream of the register file.
- Consumes the two register-file read ports (OUT1/OUT2) and produces a registered result.
- Provides a write-back destination address and a one-cycle write strobe that drive the register file's IN, INADDRESS and WRITE.
- Single-cycle logic/arithmetic ops; iterative shift-add multiply and bit-serial left shift.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/alu_mul_step.sv | 13 +
 rtl/alu_exec.sv | 163 ++++++++++++++++
 tb/tb_alu_exec.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: opcodes, default widths and FSM encoding.
package cpu_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int ADDR_W_DEF = 3;

  localparam logic [2:0] OP_FWD  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_mul_step.sv
// One shift-add multiply iteration: conditionally add the aligned multiplicand.
module alu_mul_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic               bit_i,
  output logic [2*WIDTH-1:0] acc_o
);

  assign acc_o = bit_i ? (acc_i + mcand_i) : acc_i;

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle execute stage between register-file read ports and write-back.
module alu_exec
  import cpu_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WIDTH-1:0]  DATA1,
  input  logic [WIDTH-1:0]  DATA2,
  input  logic [2:0]        SELECT,
  input  logic [ADDR_W-1:0] DEST_IN,
  input  logic              START,
  output logic [WIDTH-1:0]  RESULT,
  output logic [ADDR_W-1:0] DEST_OUT,
  output logic              WRITE_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ZERO,
  output logic              CARRY
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [WIDTH-1:0]    res_q, res_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;

  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [2:0]          op_q, op_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [2*WIDTH-1:0]  mcand_q, mcand_d;

  logic [2*WIDTH-1:0]  mul_acc;
  logic [WIDTH:0]      sum, diff;
  logic [WIDTH-1:0]    sll_next;
  logic                sll_active;
  logic [WIDTH-1:0]    op_res;
  logic                op_carry;

  alu_mul_step #(.WIDTH(WIDTH)) u_mul_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .bit_i  (b_q[0]),
    .acc_o  (mul_acc)
  );

  assign sum        = {1'b0, a_q} + {1'b0, b_q};
  assign diff       = {1'b0, a_q} - {1'b0, b_q};
  // A zero shift amount still spends one EXEC step, but leaves the value untouched.
  assign sll_active = (b_q[2:0] != 3'd0);
  assign sll_next   = sll_active ? (acc_q[WIDTH-1:0] << 1) : acc_q[WIDTH-1:0];

  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    case (op_q)
      OP_FWD: op_res = b_q;
      OP_ADD: begin op_res = sum[WIDTH-1:0];  op_carry = sum[WIDTH];  end
      OP_AND: op_res = a_q & b_q;
      OP_OR:  op_res = a_q | b_q;
      OP_SUB: begin op_res = diff[WIDTH-1:0]; op_carry = diff[WIDTH]; end
      OP_MUL: begin op_res = mul_acc[WIDTH-1:0]; op_carry = |mul_acc[2*WIDTH-1:WIDTH]; end
      OP_SLL: op_res = sll_next;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_EXEC;
          a_d     = DATA1;
          b_d     = DATA2;
          op_d    = SELECT;
          dest_d  = DEST_IN;
          mcand_d = {{WIDTH{1'b0}}, DATA1};
          acc_d   = (SELECT == OP_MUL) ? '0 : {{WIDTH{1'b0}}, DATA1};
          case (SELECT)
            OP_MUL:  cnt_d = CNT_W'(WIDTH);
            OP_SLL:  cnt_d = (DATA2[2:0] == 3'd0) ? CNT_W'(1) : CNT_W'(DATA2[2:0]);
            default: cnt_d = CNT_W'(1);
          endcase
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OP_MUL) begin
          acc_d   = mul_acc;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
        end else if (op_q == OP_SLL) begin
          acc_d = {{WIDTH{1'b0}}, sll_next};
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          // Reserved opcode completes but leaves the visible result untouched.
          if (op_q != OP_RSVD) begin
            res_d   = op_res;
            zero_d  = (op_res == '0);
            carry_d = op_carry;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and architecturally visible state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  // Operand and working datapath registers
  always_ff @(posedge CLK) begin
    a_q     <= a_d;
    b_q     <= b_d;
    op_q    <= op_d;
    acc_q   <= acc_d;
    mcand_q <= mcand_d;
  end

  assign RESULT   = res_q;
  assign DEST_OUT = dest_q;
  assign ZERO     = zero_q;
  assign CARRY    = carry_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = (state_q == ST_DONE);
  assign WRITE_EN = (state_q == ST_DONE) && (op_q != OP_RSVD);

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: latency, results, flags, reset abort and ignored requests.
module tb_alu_exec;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] DATA1 = '0;
  logic [7:0] DATA2 = '0;
  logic [2:0] SELECT = '0;
  logic [2:0] DEST_IN = '0;
  logic       START = 1'b0;
  logic [7:0] RESULT;
  logic [2:0] DEST_OUT;
  logic       WRITE_EN, BUSY, DONE, ZERO, CARRY;

  int errors = 0;
  int checks = 0;

  alu_exec dut (
    .CLK(CLK), .RESET(RESET), .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT),
    .DEST_IN(DEST_IN), .START(START), .RESULT(RESULT), .DEST_OUT(DEST_OUT),
    .WRITE_EN(WRITE_EN), .BUSY(BUSY), .DONE(DONE), .ZERO(ZERO), .CARRY(CARRY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch an operation: the tick inside is edge N.
  task automatic launch(input logic [7:0] d1, input logic [7:0] d2,
                        input logic [2:0] sel, input logic [2:0] dst);
    DATA1 = d1; DATA2 = d2; SELECT = sel; DEST_IN = dst; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Count edges until DONE is seen (bounded); also report WRITE_EN at that point.
  task automatic wait_done(output int n, output logic we);
    n = 0;
    we = 1'b0;
    while (n < 20) begin
      tick();
      n++;
      if (DONE) begin
        we = WRITE_EN;
        break;
      end
    end
  endtask

  int   lat;
  logic we;
  int   seen;

  initial begin
    tick(); tick();
    RESET = 1'b0;
    check("rst_result", RESULT, 8'h00);
    check("rst_dest", DEST_OUT, 3'd0);
    check("rst_we", WRITE_EN, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_zero", ZERO, 1'b0);
    check("rst_carry", CARRY, 1'b0);

    // ADD 0x7F + 0x01 to r2
    launch(8'h7F, 8'h01, 3'b001, 3'd2);
    check("add_busy_n", BUSY, 1'b1);
    check("add_done_n", DONE, 1'b0);
    check("add_dest_n", DEST_OUT, 3'd2);
    tick();
    check("add_result", RESULT, 8'h80);
    check("add_zero", ZERO, 1'b0);
    check("add_carry", CARRY, 1'b0);
    check("add_done", DONE, 1'b1);
    check("add_we", WRITE_EN, 1'b1);
    tick();
    check("add_done_off", DONE, 1'b0);
    check("add_we_off", WRITE_EN, 1'b0);
    check("add_busy_off", BUSY, 1'b0);

    // SUB equal operands
    launch(8'h05, 8'h05, 3'b100, 3'd1);
    wait_done(lat, we);
    check("sub0_lat", lat, 1);
    check("sub0_result", RESULT, 8'h00);
    check("sub0_zero", ZERO, 1'b1);
    check("sub0_carry", CARRY, 1'b0);
    tick();

    // SUB with borrow; operands change after edge N must not matter
    launch(8'h03, 8'h05, 3'b100, 3'd3);
    DATA1 = 8'hAA; DATA2 = 8'h00; SELECT = 3'b000; DEST_IN = 3'd7;
    wait_done(lat, we);
    check("subb_lat", lat, 1);
    check("subb_result", RESULT, 8'hFE);
    check("subb_zero", ZERO, 1'b0);
    check("subb_carry", CARRY, 1'b1);
    check("subb_dest", DEST_OUT, 3'd3);
    tick();

    // ADD carry out
    launch(8'hF0, 8'h20, 3'b001, 3'd0);
    wait_done(lat, we);
    check("addc_result", RESULT, 8'h10);
    check("addc_carry", CARRY, 1'b1);
    tick();

    // MUL 0x0F * 0x11 with an ADD request injected while busy
    launch(8'h0F, 8'h11, 3'b101, 3'd4);
    DATA1 = 8'h01; DATA2 = 8'h01; SELECT = 3'b001; DEST_IN = 3'd6; START = 1'b1;
    tick();
    check("mul_busy1", BUSY, 1'b1);
    check("mul_done1", DONE, 1'b0);
    tick();
    START = 1'b0;
    wait_done(lat, we);
    check("mul_lat", lat + 2, 8);
    check("mul_we", we, 1'b1);
    check("mul_result", RESULT, 8'hFF);
    check("mul_carry", CARRY, 1'b0);
    check("mul_zero", ZERO, 1'b0);
    check("mul_dest", DEST_OUT, 3'd4);
    tick();
    check("mul_busy_off", BUSY, 1'b0);
    tick();
    check("mul_noqueue", BUSY, 1'b0);

    // MUL overflow into the upper byte
    launch(8'h20, 8'h10, 3'b101, 3'd5);
    wait_done(lat, we);
    check("mulo_lat", lat, 8);
    check("mulo_result", RESULT, 8'h00);
    check("mulo_zero", ZERO, 1'b1);
    check("mulo_carry", CARRY, 1'b1);
    tick();

    // Logic ops and forward
    launch(8'hCC, 8'hAA, 3'b010, 3'd1);
    wait_done(lat, we);
    check("and_result", RESULT, 8'h88);
    tick();
    launch(8'hCC, 8'hAA, 3'b011, 3'd1);
    wait_done(lat, we);
    check("or_result", RESULT, 8'hEE);
    tick();
    launch(8'h12, 8'h5A, 3'b000, 3'd1);
    wait_done(lat, we);
    check("fwd_result", RESULT, 8'h5A);
    tick();

    // SLL by 3 and by 0 (DATA2=8 -> amount 0)
    launch(8'h81, 8'h03, 3'b110, 3'd2);
    wait_done(lat, we);
    check("sll3_lat", lat, 3);
    check("sll3_result", RESULT, 8'h08);
    check("sll3_carry", CARRY, 1'b0);
    tick();
    launch(8'h81, 8'h08, 3'b110, 3'd2);
    wait_done(lat, we);
    check("sll0_lat", lat, 1);
    check("sll0_result", RESULT, 8'h81);
    tick();

    // RESET at edge N+4 of a MUL
    launch(8'h0F, 8'h11, 3'b101, 3'd6);
    tick(); tick(); tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("abort_busy", BUSY, 1'b0);
    check("abort_result", RESULT, 8'h00);
    check("abort_dest", DEST_OUT, 3'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (DONE || WRITE_EN) seen++;
    end
    check("abort_nodone", seen, 0);

    // RESET and START on the same edge
    DATA1 = 8'h7F; DATA2 = 8'h01; SELECT = 3'b001; DEST_IN = 3'd2;
    RESET = 1'b1; START = 1'b1;
    tick();
    RESET = 1'b0; START = 1'b0;
    check("rststart_busy", BUSY, 1'b0);
    tick();
    check("rststart_idle", BUSY, 1'b0);
    check("rststart_done", DONE, 1'b0);
    check("rststart_result", RESULT, 8'h00);

    // ADD to 0x80, then reserved opcode holds it
    launch(8'h7F, 8'h01, 3'b001, 3'd2);
    wait_done(lat, we);
    check("add2_result", RESULT, 8'h80);
    tick();
    launch(8'h00, 8'h00, 3'b111, 3'd5);
    wait_done(lat, we);
    check("rsvd_lat", lat, 1);
    check("rsvd_we", we, 1'b0);
    check("rsvd_result", RESULT, 8'h80);
    check("rsvd_zero", ZERO, 1'b0);
    tick();
    check("rsvd_idle", BUSY, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
